// File: rtl/ram_tile_fetch.sv
// Fetches a ROWS x 16 int8 tile from a word-wide data RAM, one row (WORDS_PER_ROW
// words) at a time, and hands each packed row to the compute array over valid/ready.
module ram_tile_fetch #(
  parameter int ROWS          = 16,
  parameter int WORDS_PER_ROW = 4,
  parameter int ROW_W         = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [31:0]      base_addr_i,
  input  logic [31:0]      stride_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             ram_req_o,
  output logic [31:0]      ram_addr_o,
  input  logic [31:0]      ram_rdata_i,
  output logic             row_valid_o,
  input  logic             row_ready_i,
  output logic [ROW_W-1:0] row_data_o,
  output logic [3:0]       row_idx_o
);

  localparam int RCW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int WCW = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam logic [RCW-1:0] LAST_ROW  = RCW'(ROWS - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS_PER_ROW - 1);

  typedef enum logic [1:0] {IDLE, FETCH, OUT, DONE} state_t;

  state_t         state;
  logic [31:0]    row_base;
  logic [31:0]    stride_q;
  logic [RCW-1:0] row_cnt;
  logic [WCW-1:0] word_cnt;

  // NOTE: all state and outputs update with non-blocking assignments so every
  // branch below sees the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      row_base    <= '0;
      stride_q    <= '0;
      row_cnt     <= '0;
      word_cnt    <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      ram_req_o   <= 1'b0;
      ram_addr_o  <= '0;
      row_valid_o <= 1'b0;
      row_data_o  <= '0;
      row_idx_o   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            row_base   <= base_addr_i & ~32'h3;
            stride_q   <= stride_i & ~32'h3;
            row_cnt    <= '0;
            word_cnt   <= '0;
            busy_o     <= 1'b1;
            ram_req_o  <= 1'b1;
            ram_addr_o <= base_addr_i & ~32'h3;
            state      <= FETCH;
          end
        end

        // The address register walks row_base + 4*word_cnt one word per cycle.
        FETCH: begin
          row_data_o[32*word_cnt +: 32] <= ram_rdata_i;
          if (word_cnt == LAST_WORD) begin
            ram_req_o   <= 1'b0;
            ram_addr_o  <= '0;
            row_valid_o <= 1'b1;
            row_idx_o   <= 4'(row_cnt);
            state       <= OUT;
          end else begin
            word_cnt   <= word_cnt + 1'b1;
            ram_addr_o <= ram_addr_o + 32'd4;
          end
        end

        OUT: begin
          if (row_ready_i) begin
            row_valid_o <= 1'b0;
            if (row_cnt == LAST_ROW) begin
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              row_base   <= row_base + stride_q;
              row_cnt    <= row_cnt + 1'b1;
              word_cnt   <= '0;
              ram_req_o  <= 1'b1;
              ram_addr_o <= row_base + stride_q;
              state      <= FETCH;
            end
          end
        end

        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ram_tile_fetch.md
Name: ram_tile_fetch

Overview:
- Downstream consumer of the data RAM (byte-addressed, 32-bit words, 4096 entries, combinational read data valid in the same cycle as the request).
- Fetches one 16-row int8 tile: each row is 16 bytes read as 4 consecutive words, and rows are separated by a programmable byte stride.
- Packs each row into a 128-bit vector and hands it to the 16x16 int8 compute array over a valid/ready handshake, one row at a time.

Parameters:
- ROWS, 16, rows per tile; must be at least 1.
- WORDS_PER_ROW, 4, 32-bit words per row (16 int8 lanes).
- ROW_W, 128, row vector width; must equal 32*WORDS_PER_ROW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start_i  in  1  start tile fetch; sampled only in IDLE.
- base_addr_i  in  32  byte address of row 0, word 0; captured on accepted start.
- stride_i  in  32  byte distance between row starts; captured on accepted start.
- busy_o  out  1  high from the cycle after accepted start through the DONE cycle.
- done_o  out  1  one-cycle pulse after the last row handshake.
- ram_req_o  out  1  RAM read request.
- ram_addr_o  out  32  RAM byte address.
- ram_rdata_i  in  32  RAM read data; combinational, valid in the same cycle as ram_req_o.
- row_valid_o  out  1  row_data_o holds a complete row.
- row_ready_i  in  1  consumer accepts the row.
- row_data_o  out  ROW_W  packed row; word w occupies bits [32w+31:32w], byte 0 of word 0 at bits [7:0].
- row_idx_o  out  4  index of the row currently presented (0..ROWS-1).

Behaviour:
- Reset (synchronous): state IDLE. busy_o, done_o, ram_req_o, row_valid_o are 0; ram_addr_o, row_data_o, row_idx_o are 0; internal counters are 0.
- FSM states: IDLE, FETCH, OUT, DONE.
- IDLE:
  - start_i=1 captures base_addr_i with bits [1:0] forced to 0, and stride_i with bits [1:0] forced to 0.
  - Sets row_base to the captured base address, row counter to 0, word counter to 0, then moves to FETCH.
- FETCH:
  - ram_req_o=1 and ram_addr_o = row_base + 4*word_cnt.
  - ram_rdata_i is written into row buffer word word_cnt on the same edge.
  - After word WORDS_PER_ROW-1 is captured, moves to OUT. FETCH lasts exactly WORDS_PER_ROW cycles.
- OUT:
  - ram_req_o=0, row_valid_o=1, row_idx_o = row counter.
  - row_data_o and row_idx_o are held stable while row_ready_i=0.
  - On row_valid_o and row_ready_i both high:
    - If this is the last row (row counter = ROWS-1), moves to DONE.
    - Otherwise row_base += stride, row counter += 1, word counter = 0, and moves to FETCH.
- DONE: done_o=1 for exactly one cycle, busy_o still 1, then returns to IDLE.
- When ram_req_o=0, ram_addr_o=0.
- row_data_o keeps the last row after the tile completes, until the next fetch overwrites it.
- Latency:
  - start accepted at edge T; FETCH covers cycles T+1..T+4; row_valid_o first high at T+5.
  - With row_ready_i held at 1, each row takes 5 cycles, and done_o pulses 5*ROWS+1 cycles after start.
- Boundary conditions:
  - start_i while not IDLE is ignored; it is not queued.
  - Address arithmetic is modulo 2^32; no range check against the RAM depth.
  - stride=0 re-reads the same row ROWS times.
  - row_ready_i high outside OUT has no effect.
  - rst asserted mid-tile returns to IDLE on that edge; the partial tile is dropped and done_o does not pulse.
  - start_i in the same cycle as the DONE pulse is ignored; it is accepted from the IDLE cycle that follows.

Test Plan:
- Preload RAM word i = 32'hA000_0000+i; start with base=0x40, stride=0x10, ready=1.
  - RAM addresses 0x40..0x13C are read in order.
  - Row r data equals words 16+4r..19+4r.
  - row_valid_o first high 5 cycles after start; done_o pulses once, at cycle 81.
- base=0x103 and stride=0x23.
  - Captured values are 0x100 and 0x20; addresses requested for row 1 are 0x120..0x12C.
- Backpressure: hold ready=0 for 7 cycles on row 3, with random ready elsewhere.
  - row_data_o and row_idx_o=3 stay stable; no ram_req_o is issued during the stall.
  - Exactly 16 handshakes occur and done_o pulses once.
- start_i pulsed during FETCH, OUT and DONE.
  - All pulses ignored; single tile, single done_o pulse.
  - A new start in the cycle after DONE is accepted.
- Assert rst during OUT of row 7.
  - Next cycle: all outputs 0, state IDLE, no done_o.
  - A new start fetches from row 0 with the new base address.
- base=0xFFFF_FFF0, stride=0x10, ROWS=2.
  - Row 1 addresses wrap to 0x0..0xC.
